prm_edge_chk_seq: RTL

PRM_EDGE_CHK_SEQ -- requirements
Module: prm_edge_chk_seq

---
 rtl/prm_edge_chk_seq_pkg.sv | 20 ++
 rtl/prm_edge_chk_seq_if.sv | 32 +++
 rtl/prm_edge_chk_seq_term_match.sv | 35 +++
 rtl/prm_edge_chk_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/prm_edge_chk_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prm_chk_pkg
// Description : Shared defaults and FSM state type for the edge checker.
// Revision    : 1.0 - initial release
// ============================================================================
package prm_chk_pkg;

    localparam int c_N_IN_DEF    = 15;
    localparam int c_N_TERMS_DEF = 256;
    localparam int c_P_DEF       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prm_edge_chk_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : prm_edge_chk_seq_if
// Description : Request/result handshake bundle of the edge checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface prm_edge_chk_seq_if #(
    parameter int N_IN = 15,
    parameter int AW   = 8,
    parameter int ID_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_bits;
    logic [ID_W-1:0]   in_id;
    logic              out_valid;
    logic              out_ready;
    logic              out_mask;
    logic [ID_W-1:0]   out_id;
    logic [AW-1:0]     out_term;

    modport master (
        output in_valid, in_bits, in_id, out_ready,
        input  in_ready, out_valid, out_mask, out_id, out_term
    );

    modport slave (
        input  in_valid, in_bits, in_id, out_ready,
        output in_ready, out_valid, out_mask, out_id, out_term
    );
endinterface
`default_nettype wire

// File: rtl/prm_edge_chk_seq_term_match.sv
`default_nettype none
// ============================================================================
// Module      : prm_term_match
// Description : P parallel cube compares with lowest-index priority encode.
// Revision    : 1.0 - initial release
// ============================================================================
module prm_term_match #(
    parameter int N_IN = 15,
    parameter int P    = 4,
    parameter int OW   = 2
) (
    input  logic [N_IN-1:0]         i_bits,
    input  logic [P-1:0][N_IN-1:0]  i_care,
    input  logic [P-1:0][N_IN-1:0]  i_val,
    input  logic [P-1:0]            i_en,
    output logic                    o_hit,
    output logic [OW-1:0]           o_off
);
    logic [P-1:0] w_match;

    // Walking downwards lets the lowest matching lane overwrite the others.
    always_comb begin
        w_match = '0;
        o_hit   = 1'b0;
        o_off   = '0;
        for (int j = P - 1; j >= 0; j--) begin
            w_match[j] = i_en[j] && (((i_bits ^ i_val[j]) & i_care[j]) == '0);
            if (w_match[j]) begin
                o_hit = 1'b1;
                o_off = OW'(j);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/prm_edge_chk_seq.sv
`default_nettype none
// ============================================================================
// Module      : prm_edge_chk_seq
// Description : Sequential sum-of-products edge checker scanning P terms/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module prm_edge_chk_seq
    import prm_chk_pkg::*;
#(
    parameter int N_IN    = c_N_IN_DEF,
    parameter int N_TERMS = c_N_TERMS_DEF,
    parameter int P       = c_P_DEF,
    parameter int ID_W    = 10,
    parameter int AW      = $clog2(N_TERMS)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             cfg_we,
    input  wire logic [AW-1:0]    cfg_addr,
    input  wire logic [N_IN-1:0]  cfg_care,
    input  wire logic [N_IN-1:0]  cfg_val,
    input  wire logic [AW:0]      cfg_nterms,
    output logic                  busy,
    prm_edge_chk_seq_if.slave     bus
);
    localparam int          c_OW     = (P > 1) ? $clog2(P) : 1;
    localparam logic [AW:0] c_NT_MAX = (AW + 1)'(N_TERMS);
    localparam logic [AW:0] c_P_W    = (AW + 1)'(P);

    state_t                 r_state;
    logic [AW-1:0]          r_ptr;
    logic [AW:0]            r_nterms;
    logic [N_IN-1:0]        r_bits;
    logic                   r_out_valid;
    logic                   r_out_mask;
    logic [ID_W-1:0]        r_out_id;
    logic [AW-1:0]          r_out_term;

    logic [N_IN-1:0]        r_care [N_TERMS];
    logic [N_IN-1:0]        r_val  [N_TERMS];
    logic                   r_pend_we;
    logic [AW-1:0]          r_pend_addr;
    logic [N_IN-1:0]        r_pend_care;
    logic [N_IN-1:0]        r_pend_val;

    logic [P-1:0][N_IN-1:0] w_care;
    logic [P-1:0][N_IN-1:0] w_val;
    logic [P-1:0]           w_en;
    logic                   w_hit;
    logic [c_OW-1:0]        w_off;
    logic                   w_last;
    logic                   w_accept;

    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign busy          = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_mask  = r_out_mask;
    assign bus.out_id    = r_out_id;
    assign bus.out_term  = r_out_term;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_last        = ({1'b0, r_ptr} + c_P_W) >= r_nterms;

    // Lanes beyond the captured term count never contribute a match.
    always_comb begin
        w_care = '0;
        w_val  = '0;
        w_en   = '0;
        for (int j = 0; j < P; j++) begin
            w_care[j] = r_care[r_ptr + AW'(j)];
            w_val[j]  = r_val[r_ptr + AW'(j)];
            w_en[j]   = ({1'b0, r_ptr} + (AW + 1)'(j)) < r_nterms;
        end
    end

    prm_term_match #(
        .N_IN (N_IN),
        .P    (P),
        .OW   (c_OW)
    ) u_match (
        .i_bits (r_bits),
        .i_care (w_care),
        .i_val  (w_val),
        .i_en   (w_en),
        .o_hit  (w_hit),
        .o_off  (w_off)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_nterms    <= '0;
            r_bits      <= '0;
            r_out_valid <= 1'b0;
            r_out_mask  <= 1'b0;
            r_out_id    <= '0;
            r_out_term  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_bits   <= bus.in_bits;
                        r_out_id <= bus.in_id;
                        r_nterms <= (cfg_nterms > c_NT_MAX) ? c_NT_MAX : cfg_nterms;
                        r_ptr    <= '0;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_out_term  <= r_ptr + AW'(w_off);
                        r_out_mask  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_last) begin
                        r_out_term  <= '1;
                        r_out_mask  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_ptr <= r_ptr + AW'(P);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A write coinciding with an accept is parked and lands once the request retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_TERMS; k++) begin
                r_care[k] <= '1;
                r_val[k]  <= '1;
            end
            r_pend_we   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_care <= '0;
            r_pend_val  <= '0;
        end else if ((r_state == IDLE) && cfg_we) begin
            if (w_accept) begin
                r_pend_we   <= 1'b1;
                r_pend_addr <= cfg_addr;
                r_pend_care <= cfg_care;
                r_pend_val  <= cfg_val;
            end else begin
                r_care[cfg_addr] <= cfg_care;
                r_val[cfg_addr]  <= cfg_val;
            end
        end else if ((r_state == DONE) && bus.out_ready && r_pend_we) begin
            r_care[r_pend_addr] <= r_pend_care;
            r_val[r_pend_addr]  <= r_pend_val;
            r_pend_we           <= 1'b0;
        end
    end
endmodule
`default_nettype wire
